// File: rtl/id_ex_operand_stage_if.sv
// Bundle of every signal between the ID/EX operand stage and its surroundings:
// decode, register-file read ports, the EX/MEM forwarding source, and execute.
// "slave" is the stage's own view. "master" is the view of the environment
// that drives decode, regfile, forwarding and execute.
interface id_ex_operand_stage_if #(
  parameter int XLEN   = 64,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
);
  // decode side
  logic              id_valid;
  logic              id_ready;
  logic [XLEN-1:0]   id_pc;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic              id_uses_rs1;
  logic              id_uses_rs2;
  logic [4:0]        id_rd;
  logic [XLEN-1:0]   id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  // register file read data
  logic [XLEN-1:0]   rf_rd1;
  logic [XLEN-1:0]   rf_rd2;
  // EX/MEM forwarding source
  logic              fwd_valid;
  logic [4:0]        fwd_rd;
  logic              fwd_pending;
  logic [XLEN-1:0]   fwd_data;
  // pipeline control
  logic              flush;
  // execute side
  logic              ex_valid;
  logic              ex_ready;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_imm;
  logic [XLEN-1:0]   ex_op_a;
  logic [XLEN-1:0]   ex_op_b;
  logic [4:0]        ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  stall_cnt;

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_rd, id_imm, id_ctrl, rf_rd1, rf_rd2,
           fwd_valid, fwd_rd, fwd_pending, fwd_data, flush, ex_ready,
    output id_ready, ex_valid, ex_pc, ex_imm, ex_op_a, ex_op_b,
           ex_rd, ex_ctrl, stall_cnt
  );

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_rd, id_imm, id_ctrl, rf_rd1, rf_rd2,
           fwd_valid, fwd_rd, fwd_pending, fwd_data, flush, ex_ready,
    input  id_ready, ex_valid, ex_pc, ex_imm, ex_op_a, ex_op_b,
           ex_rd, ex_ctrl, stall_cnt
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register. The stage resolves the source operands in this
// order: x0 first, then the EX/MEM forward, then the register file. It stalls
// decode on a load-use hazard and holds a single instruction under execute
// backpressure. A new instruction can enter in the same cycle that the held
// instruction leaves.
module id_ex_operand_stage #(
  parameter int XLEN   = 64,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
) (
  input logic            clk,
  input logic            rst,   // asynchronous, active-low
  id_ex_operand_stage_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
  } ex_payload_t;

  ex_payload_t      payload_d, payload_q;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  logic             match_1, match_2;
  logic             hazard;
  logic             id_ready;
  logic             accept;
  logic [XLEN-1:0]  op_a, op_b;

  // Hazard detection and handshake.
  // A producer is forwardable only for a nonzero destination. Writes to x0 are discarded.
  assign match_1  = (bus.id_rs1 != 5'd0) & bus.fwd_valid & (bus.fwd_rd == bus.id_rs1);
  assign match_2  = (bus.id_rs2 != 5'd0) & bus.fwd_valid & (bus.fwd_rd == bus.id_rs2);
  assign hazard   = bus.id_valid & bus.fwd_pending &
                    ((bus.id_uses_rs1 & match_1) | (bus.id_uses_rs2 & match_2));
  assign id_ready = ~bus.flush & ~hazard & (~valid_q | bus.ex_ready);
  assign accept   = bus.id_valid & id_ready;

  // Operand resolution: x0, then a completed EX/MEM result, then the regfile.
  // An operand is resolved even when its source is unused, because a stalled
  // forward simply falls through to the regfile value.
  always_comb begin
    // NOTE: every signal gets a value before any branch, so no latch is inferred.
    op_a = bus.rf_rd1;
    op_b = bus.rf_rd2;
    if (bus.id_rs1 == 5'd0)                op_a = '0;
    else if (match_1 && !bus.fwd_pending)  op_a = bus.fwd_data;
    if (bus.id_rs2 == 5'd0)                op_b = '0;
    else if (match_2 && !bus.fwd_pending)  op_b = bus.fwd_data;
  end

  // Next-state selection. Flush has the highest priority, then accept, then
  // drain. Otherwise the instruction is held.
  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    cnt_d     = cnt_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d        = 1'b1;
      payload_d.pc   = bus.id_pc;
      payload_d.imm  = bus.id_imm;
      payload_d.op_a = op_a;
      payload_d.op_b = op_b;
      payload_d.rd   = bus.id_rd;
      payload_d.ctrl = bus.id_ctrl;
    end else if (valid_q && bus.ex_ready) begin
      valid_d = 1'b0;
    end
    // The stall counter saturates at all-ones. Flush cycles are not counted.
    if (hazard && !bus.flush && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the payload is reset as well as valid, so the ex_* outputs read as zero out of reset.
      valid_q   <= 1'b0;
      payload_q <= '0;
      cnt_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep register updates order-independent.
      valid_q   <= valid_d;
      payload_q <= payload_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.id_ready  = id_ready;
  assign bus.ex_valid  = valid_q;
  assign bus.ex_pc     = payload_q.pc;
  assign bus.ex_imm    = payload_q.imm;
  assign bus.ex_op_a   = payload_q.op_a;
  assign bus.ex_op_b   = payload_q.op_b;
  assign bus.ex_rd     = payload_q.rd;
  assign bus.ex_ctrl   = payload_q.ctrl;
  assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage. An instruction-level model
// tracks the held instruction and the stall count, and it is compared with the
// DUT on every falling edge. Directed literal checks pin the model to
// hand-computed values.
module tb_id_ex_operand_stage;
  localparam int XLEN   = 64;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   cmp_en = 1'b0;

  id_ex_operand_stage_if #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

  id_ex_operand_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [XLEN-1:0]   pc, imm, op_a, op_b;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
  } instr_t;

  instr_t m_held;
  bit     m_valid;
  int     m_cnt;

  // The value the instruction would read for register idx, given what the
  // older instruction in EX/MEM is doing this cycle.
  function automatic logic [XLEN-1:0] m_value(input logic [4:0] idx, input logic [XLEN-1:0] rf);
    if (idx == 5'd0) return '0;
    if (bus.fwd_valid && bus.fwd_rd == idx && !bus.fwd_pending) return bus.fwd_data;
    return rf;
  endfunction

  // True when a register the instruction actually reads is still being loaded.
  function automatic bit m_waits_on_load();
    bit r1, r2;
    r1 = bus.id_uses_rs1 && bus.id_rs1 != 5'd0 && bus.id_rs1 == bus.fwd_rd;
    r2 = bus.id_uses_rs2 && bus.id_rs2 != 5'd0 && bus.id_rs2 == bus.fwd_rd;
    return bus.id_valid && bus.fwd_valid && bus.fwd_pending && (r1 || r2);
  endfunction

  function automatic bit m_can_take();
    return !bus.flush && !m_waits_on_load() && (!m_valid || bus.ex_ready);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid = 1'b0;
      m_cnt   = 0;
      m_held  = '{pc: '0, imm: '0, op_a: '0, op_b: '0, rd: '0, ctrl: '0};
    end else begin
      bit take;
      take = bus.id_valid && m_can_take();
      if (m_waits_on_load() && !bus.flush && m_cnt < CNT_MAX) m_cnt++;
      if (bus.flush) m_valid = 1'b0;
      else if (take) begin
        m_valid     = 1'b1;
        m_held.pc   = bus.id_pc;
        m_held.imm  = bus.id_imm;
        m_held.rd   = bus.id_rd;
        m_held.ctrl = bus.id_ctrl;
        m_held.op_a = m_value(bus.id_rs1, bus.rf_rd1);
        m_held.op_b = m_value(bus.id_rs2, bus.rf_rd2);
      end else if (bus.ex_ready) m_valid = 1'b0;
    end
  end

  // Compare the DUT with the model on every falling edge.
  always @(negedge clk) begin
    if (rst && cmp_en) begin
      check("id_ready", bus.id_ready, m_can_take());
      check("ex_valid", bus.ex_valid, m_valid);
      check("stall_cnt", bus.stall_cnt, m_cnt);
      if (m_valid) begin
        check("ex_pc", bus.ex_pc, m_held.pc);
        check("ex_imm", bus.ex_imm, m_held.imm);
        check("ex_op_a", bus.ex_op_a, m_held.op_a);
        check("ex_op_b", bus.ex_op_b, m_held.op_b);
        check("ex_rd", bus.ex_rd, m_held.rd);
        check("ex_ctrl", bus.ex_ctrl, m_held.ctrl);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.id_valid = 0; bus.id_pc = '0; bus.id_rs1 = '0; bus.id_rs2 = '0;
    bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0; bus.id_rd = '0;
    bus.id_imm = '0; bus.id_ctrl = '0; bus.rf_rd1 = '0; bus.rf_rd2 = '0;
    bus.fwd_valid = 0; bus.fwd_rd = '0; bus.fwd_pending = 0; bus.fwd_data = '0;
    bus.flush = 0; bus.ex_ready = 1;
  endtask

  task automatic present(input logic [63:0] pc, input logic [4:0] rs1, input bit u1,
                         input logic [4:0] rs2, input bit u2);
    bus.id_valid = 1; bus.id_pc = pc;
    bus.id_rs1 = rs1; bus.id_uses_rs1 = u1;
    bus.id_rs2 = rs2; bus.id_uses_rs2 = u2;
    bus.id_rd   = 5'(pc >> 2);
    bus.id_imm  = ~pc;
    bus.id_ctrl = 16'(pc) ^ 16'h5A5A;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ex_valid", bus.ex_valid, 0);
    check("reset ex_pc", bus.ex_pc, 0);
    check("reset ex_op_a", bus.ex_op_a, 0);
    check("reset ex_op_b", bus.ex_op_b, 0);
    check("reset stall_cnt", bus.stall_cnt, 0);
    check("reset id_ready", bus.id_ready, 1);
    rst = 1'b1;
    cmp_en = 1'b1;

    // EX/MEM forward beats the regfile.
    present(64'h100, 5'd5, 1, 5'd3, 1);
    bus.rf_rd1 = 64'h11; bus.rf_rd2 = 64'h33;
    bus.fwd_valid = 1; bus.fwd_rd = 5'd5; bus.fwd_pending = 0; bus.fwd_data = 64'hAB;
    tick();
    check("fwd ex_valid", bus.ex_valid, 1);
    check("fwd ex_op_a", bus.ex_op_a, 64'hAB);
    check("fwd ex_op_b", bus.ex_op_b, 64'h33);
    check("fwd ex_pc", bus.ex_pc, 64'h100);

    // x0 always reads zero, even when EX/MEM targets x0.
    present(64'h104, 5'd4, 1, 5'd0, 1);
    bus.rf_rd1 = 64'h44; bus.rf_rd2 = 64'h22;
    bus.fwd_rd = 5'd0; bus.fwd_data = 64'hFF;
    #1 check("x0 id_ready", bus.id_ready, 1);
    tick();
    check("x0 ex_op_b", bus.ex_op_b, 0);
    check("x0 ex_op_a", bus.ex_op_a, 64'h44);
    present(64'h108, 5'd4, 1, 5'd0, 1);
    bus.fwd_pending = 1;
    #1 check("x0 pending no stall", bus.id_ready, 1);
    tick();
    check("x0 pending ex_op_b", bus.ex_op_b, 0);
    check("x0 stall_cnt", bus.stall_cnt, 0);

    // Load-use: two stall cycles, then the forwarded load result.
    present(64'h10C, 5'd7, 1, 5'd0, 0);
    bus.rf_rd1 = 64'h70;
    bus.fwd_rd = 5'd7; bus.fwd_pending = 1; bus.fwd_data = 64'hDEAD;
    #1 check("lu id_ready c0", bus.id_ready, 0);
    tick();
    check("lu ex_valid c1", bus.ex_valid, 0);
    check("lu stall_cnt c1", bus.stall_cnt, 1);
    check("lu id_ready c1", bus.id_ready, 0);
    tick();
    check("lu stall_cnt c2", bus.stall_cnt, 2);
    check("lu ex_valid c2", bus.ex_valid, 0);
    bus.fwd_pending = 0; bus.fwd_data = 64'h1234;
    #1 check("lu id_ready resolve", bus.id_ready, 1);
    tick();
    check("lu ex_valid", bus.ex_valid, 1);
    check("lu ex_op_a", bus.ex_op_a, 64'h1234);
    check("lu stall_cnt held", bus.stall_cnt, 2);

    // An unused source never stalls. It falls through to the regfile.
    present(64'h110, 5'd7, 0, 5'd0, 0);
    bus.fwd_pending = 1; bus.rf_rd1 = 64'h77;
    #1 check("unused id_ready", bus.id_ready, 1);
    tick();
    check("unused ex_op_a", bus.ex_op_a, 64'h77);
    check("unused stall_cnt", bus.stall_cnt, 2);

    // Backpressure holds every ex_* output.
    present(64'h200, 5'd1, 1, 5'd2, 1);
    bus.fwd_valid = 0; bus.rf_rd1 = 64'h201; bus.rf_rd2 = 64'h202;
    bus.ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 check("bp id_ready", bus.id_ready, 0);
      tick();
      check("bp ex_pc held", bus.ex_pc, 64'h110);
      check("bp ex_op_a held", bus.ex_op_a, 64'h77);
    end
    bus.ex_ready = 1;
    #1 check("bp release id_ready", bus.id_ready, 1);
    tick();
    check("bp new ex_pc", bus.ex_pc, 64'h200);
    check("bp new ex_op_a", bus.ex_op_a, 64'h201);

    // Flush wins over a valid decode and a held instruction.
    present(64'h300, 5'd1, 1, 5'd2, 1);
    bus.ex_ready = 0; bus.flush = 1;
    #1 check("flush id_ready", bus.id_ready, 0);
    tick();
    check("flush ex_valid", bus.ex_valid, 0);
    // Flush during a hazard does not count a stall.
    present(64'h304, 5'd7, 1, 5'd0, 0);
    bus.ex_ready = 1;
    bus.fwd_valid = 1; bus.fwd_rd = 5'd7; bus.fwd_pending = 1;
    tick();
    check("flush hazard stall_cnt", bus.stall_cnt, 2);
    bus.flush = 0;
    // The 2-bit stall counter saturates at 3.
    tick();
    check("sat stall_cnt 3", bus.stall_cnt, 3);
    tick();
    tick();
    check("sat stall_cnt stays", bus.stall_cnt, 3);

    // Accept, then drain to a bubble.
    bus.fwd_pending = 0; bus.fwd_data = 64'h5555;
    tick();
    check("drain accept op_a", bus.ex_op_a, 64'h5555);
    bus.id_valid = 0;
    tick();
    check("drain bubble", bus.ex_valid, 0);

    // Mixed traffic that only the model checks.
    for (int i = 0; i < 8; i++) begin
      present(64'h400 + 64'(4 * i), 5'(i % 4), 1, 5'((i + 1) % 4), 1);
      bus.rf_rd1 = 64'hA00 + 64'(i); bus.rf_rd2 = 64'hB00 + 64'(i);
      bus.fwd_valid = 1; bus.fwd_rd = 5'd2;
      bus.fwd_pending = (i % 2) == 1; bus.fwd_data = 64'h9000 + 64'(i);
      bus.ex_ready = (i % 3) != 2;
      tick();
    end

    // Asynchronous reset while an instruction is held.
    idle_inputs();
    present(64'h500, 5'd5, 1, 5'd0, 0);
    bus.rf_rd1 = 64'h55; bus.ex_ready = 0;
    tick();
    check("pre-reset ex_valid", bus.ex_valid, 1);
    #3 rst = 1'b0;
    #1;
    check("async rst ex_valid", bus.ex_valid, 0);
    check("async rst ex_op_a", bus.ex_op_a, 0);
    check("async rst stall_cnt", bus.stall_cnt, 0);
    tick();
    rst = 1'b1;
    bus.ex_ready = 1;
    tick();
    check("post-reset accept", bus.ex_op_a, 64'h55);
    idle_inputs();
    tick();
    tick();
    cmp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
